// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data memory interface.
// Models a multi-cycle data memory: a request seen in IDLE is latched, held in
// BUSY for WAIT_STATES cycles, performed at the ACCESS edge and acknowledged
// with a one-cycle ready pulse in DONE. stall freezes the pipeline meanwhile.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ready,
  output logic                  stall,
  output logic                  conflict
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACCESS,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]            count;
  logic                  rd_q;
  logic                  wr_q;
  logic [IDX_W-1:0]      addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  request;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address bits above the array index are dropped so addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address;

  assign request = mem_read | mem_write;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; requests during DONE are deliberately not looked at
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (request) state_next = (WAIT_STATES > 0) ? BUSY : ACCESS;
      BUSY:    if (count == 4'd1) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall output: combinational so the request cycle itself is frozen
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = request;
      BUSY:    stall = 1'b1;
      ACCESS:  stall = 1'b1;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Request latch, wait counter, read data and completion pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      out_data <= '0;
      ready    <= 1'b0;
      conflict <= 1'b0;
    end else begin
      ready    <= (state == ACCESS);
      conflict <= (state == ACCESS) && rd_q && wr_q;
      unique case (state)
        IDLE: begin
          if (request) begin
            rd_q   <= mem_read;
            wr_q   <= mem_write;
            addr_q <= address[IDX_W-1:0];
            data_q <= in_data;
            count  <= 4'(WAIT_STATES);
          end
        end
        BUSY: count <= count - 4'd1;
        ACCESS: begin
          if (rd_q && !wr_q) out_data <= mem[addr_q];
        end
        default: ;
      endcase
    end
  end

  // Storage array; not reset. A reset before the ACCESS edge leaves IDLE, so no write.
  always_ff @(posedge clock) begin
    if (state == ACCESS && wr_q) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (2 wait states,
// 0 wait states, 1 wait state with a 1024-word array) driven in sequence.
// Expected read data / conflict flags are computed from a reference memory
// when a request is issued, queued, and compared when ready pulses.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        mr  [3];
  logic        mw  [3];
  logic [10:0] ad  [3];
  logic [31:0] di  [3];
  logic [31:0] od  [3];
  logic        rdy [3];
  logic        stl [3];
  logic        cf  [3];

  int waits  [3] = '{2, 0, 1};
  int depths [3] = '{2048, 2048, 1024};

  typedef struct {
    int          k;
    logic [31:0] data;
    logic        conf;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] mdl [int];
  logic [31:0] model_out [3];

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(2048), .WAIT_STATES(2)) dut_w2 (
    .clock(clk), .reset_n(rst_n), .mem_read(mr[0]), .mem_write(mw[0]), .address(ad[0]),
    .in_data(di[0]), .out_data(od[0]), .ready(rdy[0]), .stall(stl[0]), .conflict(cf[0]));

  data_mem_responder #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(2048), .WAIT_STATES(0)) dut_w0 (
    .clock(clk), .reset_n(rst_n), .mem_read(mr[1]), .mem_write(mw[1]), .address(ad[1]),
    .in_data(di[1]), .out_data(od[1]), .ready(rdy[1]), .stall(stl[1]), .conflict(cf[1]));

  data_mem_responder #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1)) dut_d1k (
    .clock(clk), .reset_n(rst_n), .mem_read(mr[2]), .mem_write(mw[2]), .address(ad[2]),
    .in_data(di[2]), .out_data(od[2]), .ready(rdy[2]), .stall(stl[2]), .conflict(cf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b0;
      mw[i] = 1'b0;
    end
  endtask

  // Called at posedge+1; issues one access on instance k and follows it to DONE.
  // Returns at posedge+1 of the IDLE cycle after DONE with requests dropped.
  task automatic do_access(input int k, input logic rd, input logic wr, input logic [10:0] a,
                           input logic [31:0] d, input bit hold, input bit alter);
    sb_t e;
    sb_t got;
    bit  seen;
    int  key;
    key = k * 4096 + (int'(a) % depths[k]);
    if (wr) mdl[key] = d;
    else if (rd) model_out[k] = mdl.exists(key) ? mdl[key] : 32'h0;
    e.k    = k;
    e.conf = rd & wr;
    e.data = model_out[k];
    sbq.push_back(e);
    mr[k] = rd;
    mw[k] = wr;
    ad[k] = a;
    di[k] = d;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (rdy[k]) begin
        seen = 1'b1;
        chk("ready_cycle", 32'(c), 32'(waits[k] + 2));
        chk("stall_in_done", 32'(stl[k]), 32'd0);
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
          got = sbq.pop_front();
          chk("sb_instance", 32'(k), 32'(got.k));
          chk("out_data", od[k], got.data);
          chk("conflict", 32'(cf[k]), 32'(got.conf));
        end
      end else begin
        chk("stall", 32'(stl[k]), 32'(c < waits[k] + 2));
        chk("conflict_quiet", 32'(cf[k]), 32'd0);
      end
      if (alter && c == 1) ad[k] = a ^ 11'h001;
      if (!seen) begin
        @(posedge clk);
        #1;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    if (!hold) drop_all();
    @(posedge clk);
    #1;
    drop_all();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b0;
      mw[i] = 1'b0;
      ad[i] = '0;
      di[i] = '0;
      model_out[i] = '0;
    end

    // Reset values
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_data", od[i], 32'h0);
      chk("rst_ready", 32'(rdy[i]), 32'd0);
      chk("rst_stall", 32'(stl[i]), 32'd0);
      chk("rst_conflict", 32'(cf[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two wait states: write then read back, data held afterwards
    do_access(0, 1'b0, 1'b1, 11'h005, 32'hDEADBEEF, 1'b0, 1'b0);
    do_access(0, 1'b1, 1'b0, 11'h005, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_out_data", od[0], 32'hDEADBEEF);
      chk("hold_ready", 32'(rdy[0]), 32'd0);
      @(posedge clk);
      #1;
    end

    // Zero wait states at the top address
    do_access(1, 1'b0, 1'b1, 11'h7FF, 32'h12345678, 1'b0, 1'b0);
    do_access(1, 1'b1, 1'b0, 11'h7FF, 32'h0, 1'b0, 1'b0);

    // Address change during BUSY must not affect the latched request
    do_access(0, 1'b0, 1'b1, 11'h010, 32'hA5A5A5A5, 1'b0, 1'b0);
    do_access(0, 1'b0, 1'b1, 11'h011, 32'h5A5A5A5A, 1'b0, 1'b0);
    do_access(0, 1'b1, 1'b0, 11'h010, 32'h0, 1'b0, 1'b1);

    // Read and write together: write happens, out_data unchanged, conflict pulses
    do_access(0, 1'b0, 1'b1, 11'h040, 32'h11111111, 1'b0, 1'b0);
    do_access(0, 1'b1, 1'b0, 11'h040, 32'h0, 1'b0, 1'b0);
    do_access(0, 1'b1, 1'b1, 11'h020, 32'h0000FFFF, 1'b0, 1'b0);
    do_access(0, 1'b1, 1'b0, 11'h020, 32'h0, 1'b0, 1'b0);

    // Request held through DONE must not start a second access
    do_access(0, 1'b1, 1'b0, 11'h005, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("no_second_stall", 32'(stl[0]), 32'd0);
      chk("no_second_ready", 32'(rdy[0]), 32'd0);
      @(posedge clk);
      #1;
    end

    // 1024-word array: 0x400 aliases 0x000
    do_access(2, 1'b0, 1'b1, 11'h400, 32'h600DCAFE, 1'b0, 1'b0);
    do_access(2, 1'b1, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0);

    // Reset in BUSY aborts a pending write
    do_access(0, 1'b0, 1'b1, 11'h030, 32'h0BADF00D, 1'b0, 1'b0);
    mw[0] = 1'b1;
    ad[0] = 11'h030;
    di[0] = 32'hCAFE0001;
    @(posedge clk);
    #1;
    chk("busy_before_reset", 32'(stl[0]), 32'd1);
    rst_n = 1'b0;
    drop_all();
    #1;
    chk("midrst_out_data", od[0], 32'h0);
    chk("midrst_ready", 32'(rdy[0]), 32'd0);
    chk("midrst_stall", 32'(stl[0]), 32'd0);
    for (int i = 0; i < 3; i++) model_out[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_access(0, 1'b1, 1'b0, 11'h030, 32'h0, 1'b0, 1'b0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
